twd_mul_triv_pipe: RTL and testbench
====================================

Name: twd_mul_triv_pipe

Overview:
- Parametrised trivial/near-trivial twiddle multiplier for the radix-2^2 FFT datapath.
- Sits between a butterfly stage and the next stage.
- Processes LANES complex samples per beat and tracks each sample's position within an NPOINT frame.
- Applies either the W4 pattern (x1 / x(-j)) or the W8 pattern (adds x W8^1 and x W8^3 via constant multiply), with a 2-stage registered pipeline, valid/ready handshake, rounding and saturation.

Parameters:
- WIDTH, 13, signed sample width (re and im).
- LANES, 16, samples per beat; power of two; divides NPOINT.
- NPOINT, 512, frame length in samples; multiple of GROUP.
- GROUP, 8, twiddle pattern period in samples; multiple of 8.
- CW, 8, fractional bits of the 1/sqrt2 constant; C = round(2^CW/sqrt2), which is 181 for CW=8.

Ports:
- clk, in, 1: clock.
- rstn, in, 1: reset; asynchronous, active-low.
- sync_clr, in, 1: synchronous clear of position counter and pipeline.
- mode, in, 1: 0 = W4, 1 = W8; sampled only at frame start.
- in_valid, in, 1: input beat valid.
- in_ready, out, 1: block accepts the beat.
- in_re / in_im, in, WIDTH x LANES signed arrays: input samples, lane j is position base+j.
- out_valid, out, 1: output beat valid.
- out_ready, in, 1: downstream accepts.
- out_re / out_im, out, WIDTH x LANES signed arrays: twiddled samples.
- out_first, out, 1: output beat is the first beat of a frame.
- out_last, out, 1: output beat is the last beat of a frame.
- sat_cnt, out, 16: saturation event count (see Optional Feature).

Behaviour:
- Reset (rstn low, async), and sync_clr on a clock edge: base=0, both pipeline valids=0, mode_q=0, all outputs 0, sat_cnt=0. sync_clr has priority over every other event in the same cycle.
- Handshake:
  - in_ready = !v2 || out_ready, where v1 and v2 are the stage valids.
  - Input is accepted when in_valid && in_ready.
  - The pipeline advances only when in_ready=1; otherwise all stages hold.
  - Output is held stable while out_valid && !out_ready.
- Latency: 2 cycles from acceptance to out_valid with no stall.
- Position: base steps by LANES on each accepted beat and wraps from NPOINT-LANES to 0. mode_q <= mode on an accepted beat with base==0.
- Per-lane index: n = (base+j) mod GROUP, s = GROUP/8, m = n / s (0..7).
- W4 (mode_q=0): factor is -j when m>=6 (last quarter), else 1.
- W8 (mode_q=1): factor by m = 0..7 is 1,1,1,1,1,-j,W8^1,W8^3.
- Arithmetic:
  - x1: out = in.
  - -j: re' = im, im' = -re.
  - W8^1: re' = (re+im)*C, im' = (im-re)*C.
  - W8^3: re' = (im-re)*C, im' = -(re+im)*C.
  - Sums are WIDTH+1 bits. Products are rounded by adding 2^(CW-1) and arithmetic-shifting right CW.
- Saturation:
  - All results saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Negating -2^(WIDTH-1) yields +2^(WIDTH-1)-1.
- Stage split:
  - Stage 1 registers the operands, the factor code (2 bits) and the first/last flags. first = (base==0), last = (base==NPOINT-LANES).
  - Stage 2 registers the final results.
- mode changes mid-frame have no effect until the next frame-start beat.
- Back-to-back frames: no bubble required; out_last of frame k may be followed directly by out_first of frame k+1.

Optional Feature:
- Macro: TWD_SAT_CNT_EN.
- Defined: sat_cnt increments by 1 on each stage-2 register update in which at least one lane component saturated. It sticks at 16'hFFFF, and is cleared by reset or sync_clr.
- Undefined: no counter logic is built and sat_cnt is tied to 0.

Test Plan:
- W4, defaults, 32 beats, lane value re=100, im=-50: positions with (k mod 8) in {6,7} give re=-50, im=-100; all others pass unchanged; out_first on beats 0 and 32 of the stream, out_last on beat 31; latency 2.
- W8, defaults, re=1000, im=0:
  - position k mod 8 = 6 gives re=707, im=-707 (1000*181=181000, +128, >>8 = 707).
  - position 7 gives re=-707, im=-707.
  - position 5 gives re=0, im=-1000.
- Saturation: W4, re=-4096 at position 6 gives im=+4095. W8, re=im=4095 at position 6 gives re=5791, saturated to 4095. sat_cnt increments once per affected beat (TWD_SAT_CNT_EN defined) or stays 0 (undefined).
- Backpressure: hold out_ready=0 for 5 cycles mid-stream. in_ready drops once stage 2 is full, outputs stay stable, and no beat is lost or duplicated; compare the full sequence against the model.
- Mode switch: toggle mode at beat 10 of frame 0. Frame 0 stays fully W4; frame 1 is W8.
- sync_clr at beat 7, and async rstn mid-frame: out_valid is 0 the next cycle, and the next accepted beat is treated as base 0 with out_first=1.

Source files
------------

// File: rtl/twd_mul_triv_pipe.sv
// Trivial/near-trivial twiddle multiplier (W4 or W8 pattern) with a 2-stage valid/ready pipeline.
// Build option: define TWD_SAT_CNT_EN to include the saturation event counter on o_sat_cnt.
module twd_mul_triv_pipe #(
    parameter int unsigned WIDTH  = 13,
    parameter int unsigned LANES  = 16,
    parameter int unsigned NPOINT = 512,
    parameter int unsigned GROUP  = 8,
    parameter int unsigned CW     = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        i_sync_clr,
    input  logic                        i_mode,
    input  logic                        i_in_valid,
    output logic                        o_in_ready,
    input  logic [LANES-1:0][WIDTH-1:0] i_in_re,
    input  logic [LANES-1:0][WIDTH-1:0] i_in_im,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    output logic [LANES-1:0][WIDTH-1:0] o_out_re,
    output logic [LANES-1:0][WIDTH-1:0] o_out_im,
    output logic                        o_out_first,
    output logic                        o_out_last,
    output logic [15:0]                 o_sat_cnt
);

    localparam int unsigned BW = (NPOINT > 1) ? $clog2(NPOINT) : 1;
    localparam int unsigned PW = WIDTH + CW + 4;
    localparam int unsigned S  = GROUP / 8;

    // round(2^CW / sqrt2) == round(sqrt(2^(2*CW-1)))
    function automatic int unsigned isqrt_rnd(input int unsigned n);
        int unsigned r;
        int unsigned t;
        r = 0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (32'd1 << b);
            if (t * t <= n) r = t;
        end
        if (n > r * r + r) r = r + 1;
        return r;
    endfunction

    localparam int unsigned            C         = isqrt_rnd(32'd1 << (2 * CW - 1));
    localparam logic signed [PW-1:0]   CS        = PW'(C);
    localparam logic signed [PW-1:0]   RND_ADD   = PW'(2 ** (CW - 1));
    localparam logic signed [PW-1:0]   MAXV      = PW'(2 ** (WIDTH - 1) - 1);
    localparam logic signed [PW-1:0]   MINV      = ~MAXV;
    localparam logic [BW-1:0]          LAST_BASE = BW'(NPOINT - LANES);
    localparam logic [BW-1:0]          STEP      = BW'(LANES);

    typedef enum logic [1:0] {FacOne, FacNegJ, FacW81, FacW83} fac_e;

    function automatic fac_e lane_code(input logic [BW-1:0] base, input int unsigned lane,
                                       input logic mode);
        int unsigned m;
        m = ((32'(base) + lane) % GROUP) / S;
        if (!mode) return (m >= 6) ? FacNegJ : FacOne;
        if (m == 5) return FacNegJ;
        if (m == 6) return FacW81;
        if (m == 7) return FacW83;
        return FacOne;
    endfunction

    function automatic logic signed [PW-1:0] rnd(input logic signed [PW-1:0] p);
        return (p + RND_ADD) >>> CW;
    endfunction

    function automatic logic [WIDTH-1:0] sat(input logic signed [PW-1:0] v);
        if (v > MAXV) return MAXV[WIDTH-1:0];
        if (v < MINV) return MINV[WIDTH-1:0];
        return v[WIDTH-1:0];
    endfunction

    // Unsaturated results packed as {re, im}.
    function automatic logic [2*PW-1:0] lane_pre(input logic [WIDTH-1:0] a_re,
                                                 input logic [WIDTH-1:0] a_im,
                                                 input fac_e code);
        logic signed [PW-1:0] x_re, x_im, x_sum, x_dif, y_re, y_im;
        x_re  = PW'($signed(a_re));
        x_im  = PW'($signed(a_im));
        x_sum = x_re + x_im;
        x_dif = x_im - x_re;
        unique case (code)
            FacNegJ: begin
                y_re = x_im;
                y_im = -x_re;
            end
            FacW81: begin
                y_re = rnd(x_sum * CS);
                y_im = rnd(x_dif * CS);
            end
            FacW83: begin
                y_re = rnd(x_dif * CS);
                y_im = rnd((-x_sum) * CS);
            end
            default: begin
                y_re = x_re;
                y_im = x_im;
            end
        endcase
        return {y_re, y_im};
    endfunction

    logic [BW-1:0]                r_base;
    logic                         r_mode_q;
    logic                         r_v1, r_v2;
    logic [LANES-1:0][WIDTH-1:0]  r_re1, r_im1, r_re2, r_im2;
    logic [LANES-1:0][1:0]        r_code1;
    logic                         r_first1, r_last1, r_first2, r_last2;

    logic                         w_adv, w_acc, w_mode_eff;
    logic [LANES-1:0][1:0]        w_code;
    logic [LANES-1:0][2*PW-1:0]   w_pre;
    logic [LANES-1:0][WIDTH-1:0]  w_res_re, w_res_im;

    assign o_in_ready = !r_v2 || i_out_ready;
    assign w_adv      = o_in_ready;
    assign w_acc      = i_in_valid && o_in_ready;
    // The frame-start beat already uses the newly sampled mode.
    assign w_mode_eff = (r_base == '0) ? i_mode : r_mode_q;

    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            w_code[j]   = lane_code(r_base, j, w_mode_eff);
            w_pre[j]    = lane_pre(r_re1[j], r_im1[j], fac_e'(r_code1[j]));
            w_res_re[j] = sat(w_pre[j][2*PW-1:PW]);
            w_res_im[j] = sat(w_pre[j][PW-1:0]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_base   <= '0;
            r_mode_q <= 1'b0;
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_re1    <= '0;
            r_im1    <= '0;
            r_code1  <= '0;
            r_first1 <= 1'b0;
            r_last1  <= 1'b0;
            r_re2    <= '0;
            r_im2    <= '0;
            r_first2 <= 1'b0;
            r_last2  <= 1'b0;
        end else if (i_sync_clr) begin
            r_base   <= '0;
            r_mode_q <= 1'b0;
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_re1    <= '0;
            r_im1    <= '0;
            r_code1  <= '0;
            r_first1 <= 1'b0;
            r_last1  <= 1'b0;
            r_re2    <= '0;
            r_im2    <= '0;
            r_first2 <= 1'b0;
            r_last2  <= 1'b0;
        end else if (w_adv) begin
            if (w_acc) begin
                r_base   <= (r_base == LAST_BASE) ? '0 : r_base + STEP;
                if (r_base == '0) r_mode_q <= i_mode;
                r_re1    <= i_in_re;
                r_im1    <= i_in_im;
                r_code1  <= w_code;
                r_first1 <= (r_base == '0);
                r_last1  <= (r_base == LAST_BASE);
            end
            r_v1 <= w_acc;
            r_v2 <= r_v1;
            if (r_v1) begin
                r_re2    <= w_res_re;
                r_im2    <= w_res_im;
                r_first2 <= r_first1;
                r_last2  <= r_last1;
            end
        end
    end

    assign o_out_valid = r_v2;
    assign o_out_re    = r_re2;
    assign o_out_im    = r_im2;
    assign o_out_first = r_first2;
    assign o_out_last  = r_last2;

`ifdef TWD_SAT_CNT_EN
    function automatic logic ovf(input logic signed [PW-1:0] v);
        return (v > MAXV) || (v < MINV);
    endfunction

    logic        w_any_sat;
    logic [15:0] r_sat_cnt;

    always_comb begin
        w_any_sat = 1'b0;
        for (int j = 0; j < LANES; j++) begin
            w_any_sat = w_any_sat | ovf(w_pre[j][2*PW-1:PW]) | ovf(w_pre[j][PW-1:0]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sat_cnt <= '0;
        end else if (i_sync_clr) begin
            r_sat_cnt <= '0;
        end else if (w_adv && r_v1 && w_any_sat && (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign o_sat_cnt = r_sat_cnt;
`else
    assign o_sat_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_twd_mul_triv_pipe.sv
// Scoreboard bench for twd_mul_triv_pipe: W4/W8 patterns, saturation, stalls, mode and clears.
module tb_twd_mul_triv_pipe;

    localparam int WIDTH  = 13;
    localparam int LANES  = 16;
    localparam int NPOINT = 512;
    localparam int GROUP  = 8;
    localparam int C      = 181;

    logic                        clk;
    logic                        rstn;
    logic                        i_sync_clr;
    logic                        i_mode;
    logic                        i_in_valid;
    logic                        o_in_ready;
    logic [LANES-1:0][WIDTH-1:0] i_in_re;
    logic [LANES-1:0][WIDTH-1:0] i_in_im;
    logic                        o_out_valid;
    logic                        i_out_ready;
    logic [LANES-1:0][WIDTH-1:0] o_out_re;
    logic [LANES-1:0][WIDTH-1:0] o_out_im;
    logic                        o_out_first;
    logic                        o_out_last;
    logic [15:0]                 o_sat_cnt;

    twd_mul_triv_pipe dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_sync_clr  (i_sync_clr),
        .i_mode      (i_mode),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_re     (i_in_re),
        .i_in_im     (i_in_im),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_re    (o_out_re),
        .o_out_im    (o_out_im),
        .o_out_first (o_out_first),
        .o_out_last  (o_out_last),
        .o_sat_cnt   (o_sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [LANES-1:0][WIDTH-1:0] re;
        logic [LANES-1:0][WIDTH-1:0] im;
        logic                        first;
        logic                        last;
    } beat_t;

    beat_t sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    m_base = 0;
    bit    m_mode = 1'b0;

    function automatic int rnd(int p);
        return (p + 128) >>> 8;
    endfunction

    function automatic int sat13(int v, inout bit s);
        if (v > 4095) begin s = 1'b1; return 4095; end
        if (v < -4096) begin s = 1'b1; return -4096; end
        return v;
    endfunction

    task automatic push_model();
        beat_t e;
        bit    s;
        int    re, im, ore, oim, k;
        s = 1'b0;
        if (m_base == 0) m_mode = i_mode;
        for (int j = 0; j < LANES; j++) begin
            re = $signed(i_in_re[j]);
            im = $signed(i_in_im[j]);
            k  = (m_base + j) % GROUP;
            if ((!m_mode && k >= 6) || (m_mode && k == 5)) begin
                ore = im;
                oim = -re;
            end else if (m_mode && k == 6) begin
                ore = rnd((re + im) * C);
                oim = rnd((im - re) * C);
            end else if (m_mode && k == 7) begin
                ore = rnd((im - re) * C);
                oim = rnd(-(re + im) * C);
            end else begin
                ore = re;
                oim = im;
            end
            e.re[j] = WIDTH'(sat13(ore, s));
            e.im[j] = WIDTH'(sat13(oim, s));
        end
        e.first = (m_base == 0);
        e.last  = (m_base == NPOINT - LANES);
        sb.push_back(e);
        m_base = (m_base + LANES) % NPOINT;
    endtask

    // One clock: scoreboard pop on output handshake, model push on input handshake.
    task automatic tick();
        beat_t e;
        @(negedge clk);
        if (i_sync_clr) begin
            sb.delete();
            m_base = 0;
            m_mode = 1'b0;
        end else begin
            if (o_out_valid && i_out_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_extra: got unexpected beat re=%h, required no beat", o_out_re);
                end else begin
                    e = sb.pop_front();
                    if ({o_out_re, o_out_im, o_out_first, o_out_last} !==
                        {e.re, e.im, e.first, e.last}) begin
                        n_bad++;
                        $display("FAIL sb_beat: got re=%h im=%h f=%b l=%b, required re=%h im=%h f=%b l=%b",
                                 o_out_re, o_out_im, o_out_first, o_out_last,
                                 e.re, e.im, e.first, e.last);
                    end
                end
            end
            if (i_in_valid && o_in_ready) push_model();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        i_in_valid  = 1'b0;
        i_out_ready = 1'b1;
        while ((sb.size() != 0 || o_out_valid) && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending beats, required 0", sb.size());
        end
    endtask

    task automatic do_sync_clr();
        i_in_valid = 1'b0;
        i_sync_clr = 1'b1;
        tick();
        i_sync_clr = 1'b0;
    endtask

    task automatic set_beat(int re, int im);
        for (int j = 0; j < LANES; j++) begin
            i_in_re[j] = WIDTH'(re);
            i_in_im[j] = WIDTH'(im);
        end
    endtask

    task automatic rand_beat();
        for (int j = 0; j < LANES; j++) begin
            i_in_re[j] = WIDTH'($urandom);
            i_in_im[j] = WIDTH'($urandom);
        end
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if (o_out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b, required 0", o_out_valid); end
        n_cmp++;
        if ({o_out_first, o_out_last} !== 2'b00) begin
            n_bad++; $display("FAIL rst_flags: got %b, required 00", {o_out_first, o_out_last});
        end
        n_cmp++;
        if (o_out_re !== '0 || o_out_im !== '0) begin
            n_bad++; $display("FAIL rst_data: got re=%h im=%h, required 0", o_out_re, o_out_im);
        end
        n_cmp++;
        if (o_sat_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_satcnt: got %0d, required 0", o_sat_cnt); end
        n_cmp++;
        if (o_in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b, required 1", o_in_ready); end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_w4();
        i_mode = 1'b0;
        i_out_ready = 1'b1;
        set_beat(100, -50);
        i_in_valid = 1'b1;
        tick();
        n_cmp++;
        if (o_out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_early: got %b, required 0", o_out_valid); end
        tick();
        n_cmp++;
        if (o_out_valid !== 1'b1 || o_out_first !== 1'b1) begin
            n_bad++; $display("FAIL lat_2: got v=%b f=%b, required 1 1", o_out_valid, o_out_first);
        end
        for (int b = 2; b < 33; b++) tick();
        drain();
    endtask

    task automatic test_w8();
        do_sync_clr();
        i_mode = 1'b1;
        set_beat(1000, 0);
        i_in_valid = 1'b1;
        tick();
        i_in_valid = 1'b0;
        tick();
        n_cmp++;
        if (int'($signed(o_out_re[6])) != 707 || int'($signed(o_out_im[6])) != -707) begin
            n_bad++; $display("FAIL w8_pos6: got %0d %0d, required 707 -707",
                              $signed(o_out_re[6]), $signed(o_out_im[6]));
        end
        n_cmp++;
        if (int'($signed(o_out_re[7])) != -707 || int'($signed(o_out_im[7])) != -707) begin
            n_bad++; $display("FAIL w8_pos7: got %0d %0d, required -707 -707",
                              $signed(o_out_re[7]), $signed(o_out_im[7]));
        end
        n_cmp++;
        if (int'($signed(o_out_re[5])) != 0 || int'($signed(o_out_im[5])) != -1000) begin
            n_bad++; $display("FAIL w8_pos5: got %0d %0d, required 0 -1000",
                              $signed(o_out_re[5]), $signed(o_out_im[5]));
        end
        drain();
    endtask

    task automatic test_sat();
        int exp_cnt;
        do_sync_clr();
        i_mode = 1'b0;
        i_out_ready = 1'b1;
        set_beat(-4096, 0);
        i_in_valid = 1'b1;
        tick();
        set_beat(0, 0);
        tick();
        n_cmp++;
        if (int'($signed(o_out_im[6])) != 4095 || int'($signed(o_out_re[6])) != 0) begin
            n_bad++; $display("FAIL sat_negj: got re=%0d im=%0d, required 0 4095",
                              $signed(o_out_re[6]), $signed(o_out_im[6]));
        end
        for (int b = 2; b < 32; b++) tick();
        i_mode = 1'b1;
        set_beat(4095, 4095);
        tick();
        tick();
        n_cmp++;
        if (int'($signed(o_out_re[6])) != 4095 || int'($signed(o_out_im[6])) != 0) begin
            n_bad++; $display("FAIL sat_w81: got re=%0d im=%0d, required 4095 0",
                              $signed(o_out_re[6]), $signed(o_out_im[6]));
        end
        drain();
`ifdef TWD_SAT_CNT_EN
        exp_cnt = 3;
`else
        exp_cnt = 0;
`endif
        n_cmp++;
        if (int'(o_sat_cnt) != exp_cnt) begin
            n_bad++; $display("FAIL sat_cnt: got %0d, required %0d", o_sat_cnt, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [LANES-1:0][WIDTH-1:0] h_re, h_im;
        logic                        h_f, h_l;
        int                          sent, c;
        bit                          acc;
        do_sync_clr();
        i_mode = 1'b1;
        rand_beat();
        i_in_valid = 1'b1;
        sent = 0;
        c = 0;
        while (sent < 20 && c < 100) begin
            i_out_ready = !(c >= 6 && c < 11);
            #1;
            if (c == 6) begin
                h_re = o_out_re; h_im = o_out_im; h_f = o_out_first; h_l = o_out_last;
                n_cmp++;
                if (o_in_ready !== 1'b0 || o_out_valid !== 1'b1) begin
                    n_bad++; $display("FAIL bp_ready: got rdy=%b v=%b, required 0 1", o_in_ready, o_out_valid);
                end
            end else if (c > 6 && c < 11) begin
                n_cmp++;
                if ({o_out_re, o_out_im, o_out_first, o_out_last, o_out_valid} !==
                    {h_re, h_im, h_f, h_l, 1'b1}) begin
                    n_bad++; $display("FAIL bp_hold: got re=%h, required re=%h", o_out_re, h_re);
                end
            end
            acc = o_in_ready;
            tick();
            c++;
            if (acc) begin
                sent++;
                rand_beat();
            end
        end
        if (sent < 20) begin
            n_cmp++; n_bad++; $display("FAIL bp_timeout: got %0d beats sent, required 20", sent);
        end
        drain();
    endtask

    task automatic test_mode_switch();
        do_sync_clr();
        i_mode = 1'b0;
        i_out_ready = 1'b1;
        i_in_valid = 1'b1;
        for (int b = 0; b < 40; b++) begin
            if (b == 10) i_mode = 1'b1;
            rand_beat();
            tick();
        end
        drain();
        i_mode = 1'b0;
    endtask

    task automatic test_clears();
        do_sync_clr();
        i_mode = 1'b0;
        i_out_ready = 1'b1;
        i_in_valid = 1'b1;
        for (int b = 0; b < 7; b++) begin rand_beat(); tick(); end
        i_sync_clr = 1'b1;
        tick();
        i_sync_clr = 1'b0;
        n_cmp++;
        if (o_out_valid !== 1'b0) begin n_bad++; $display("FAIL clr_valid: got %b, required 0", o_out_valid); end
        rand_beat();
        tick();
        i_in_valid = 1'b0;
        tick();
        n_cmp++;
        if (o_out_valid !== 1'b1 || o_out_first !== 1'b1) begin
            n_bad++; $display("FAIL clr_first: got v=%b f=%b, required 1 1", o_out_valid, o_out_first);
        end
        drain();
        i_in_valid = 1'b1;
        for (int b = 0; b < 5; b++) begin rand_beat(); tick(); end
        #2;
        rstn = 1'b0;
        i_in_valid = 1'b0;
        #1;
        n_cmp++;
        if (o_out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid: got %b, required 0", o_out_valid); end
        sb.delete();
        m_base = 0;
        m_mode = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        rand_beat();
        i_in_valid = 1'b1;
        tick();
        i_in_valid = 1'b0;
        tick();
        n_cmp++;
        if (o_out_valid !== 1'b1 || o_out_first !== 1'b1) begin
            n_bad++; $display("FAIL arst_first: got v=%b f=%b, required 1 1", o_out_valid, o_out_first);
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn        = 1'b0;
        i_sync_clr  = 1'b0;
        i_mode      = 1'b0;
        i_in_valid  = 1'b0;
        i_out_ready = 1'b1;
        set_beat(0, 0);
        test_reset();
        test_w4();
        test_w8();
        test_sat();
        test_backpressure();
        test_mode_switch();
        test_clears();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
